irq_sequencer: RTL and testbench
================================

# irq_sequencer

Sequences external interrupt sources into the single-cycle LEGv8 core's one-line exception interface. It edge-detects up to N_SRC interrupt lines, latches them as pending, applies a writable enable mask and picks one by fixed priority. It then runs the ExtIRQ/ExtIAck handshake with the core controller and holds the in-service state until the handler's ERET. It sits between the platform interrupt lines and the controller's ExtIRQ input; its irq_id output is the handler's source index.

## Interface
Parameters:
- N_SRC, 4, number of interrupt source lines (2..16)
- ID_W, 2, width of irq_id; must equal ceil(log2(N_SRC))

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- irq_in  in  N_SRC  interrupt lines, synchronous to clk, rising-edge sensed
- mask_we  in  1  write enable for the enable mask
- mask_wdata  in  N_SRC  new mask value (bit i = 1 enables source i)
- ExtIAck  in  1  acceptance strobe from the controller (ExcAck & ExtIRQ)
- ERet  in  1  ERET executing (end of handler)
- ExtIRQ  out  1  interrupt request to the controller
- irq_id  out  ID_W  index of the requested or granted source
- in_service  out  1  handler currently running
- pending  out  N_SRC  pending latches, readable for debug and CSR

## Operation
- Registers:
  - irq_prev[N_SRC]: previous sample of irq_in; resets to all ones, so lines already high at reset release never trigger.
  - pending[N_SRC]: resets to 0.
  - mask[N_SRC]: resets to all ones.
  - sel_id[ID_W]: resets to 0.
  - state: resets to IDLE.
- Edge detect: `edge = irq_in & ~irq_prev`. For each i, `pending[i]` is set by `edge[i]` and cleared only by a grant of source i. If a set and a clear hit the same bit in the same cycle, the set wins.
- Mask write: `mask <= mask_wdata` when mask_we. Masking affects eligibility only and never clears pending.
- `eligible = pending & mask`. Priority is the lowest eligible index.
- State IDLE:
  - If eligible ≠ 0, sel_id <= lowest eligible index and the next state is REQ.
  - ExtIAck and ERet are ignored.
- State REQ:
  - ExtIRQ = 1. irq_id is frozen at sel_id; a higher-priority arrival does not re-arbitrate.
  - On ExtIAck, clear pending[sel_id] and go to SERVICE.
  - Else if mask (after this cycle's write) or pending no longer enables sel_id, withdraw and go to IDLE.
  - If ExtIAck and a mask write disabling sel_id arrive together, the ack wins.
- State SERVICE:
  - in_service = 1 and ExtIRQ = 0. There is no nesting; new edges only accumulate in pending.
  - On ERet, go to IDLE. ExtIAck is ignored.
- Outputs:
  - ExtIRQ = (state == REQ).
  - in_service = (state == SERVICE).
  - irq_id = sel_id. It holds the last granted ID through SERVICE and IDLE.
- Reset at any time, including mid-REQ or mid-SERVICE, returns every register to its reset value; pending events are discarded.
- Reset values of outputs: ExtIRQ 0, in_service 0, irq_id 0, pending 0.

## Timing
- Edge at irq_in[i] sampled at clock edge k sets pending[i], visible after edge k.
- If IDLE and mask[i] = 1, state becomes REQ and ExtIRQ = 1 after edge k+1. Latency is 2 cycles from the sampled edge to the request.
- ExtIAck sampled high at edge m in REQ: after edge m, ExtIRQ = 0, in_service = 1 and pending[sel_id] = 0. The controller never sees ExtIRQ high for more than one cycle past its ack.
- ERet sampled at edge n in SERVICE gives IDLE after edge n. The earliest next ExtIRQ is after edge n+1.
- A line held high generates one event; it must drop and rise again to re-trigger.

## Structure
- Package `irq_pkg`:
  - `typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_state_t`
  - Default constants N_SRC_DEF = 4 and ID_W_DEF = 2
- Sub-module `prio_enc` (parameter N_SRC):
  - Combinational lowest-index-first encoder.
  - Outputs: valid and index[ID_W].
  - Instantiated once on `eligible`.
- The rest (edge detect, pending, mask, FSM) is flat in irq_sequencer. Expected size is roughly 150–250 RTL lines.

## Test plan
- Reset with irq_in = 4'b0010 held → no pending, ExtIRQ stays 0. Drop then raise line 1 → pending = 4'b0010; ExtIRQ = 1 with irq_id = 1 exactly 2 cycles after the rise.
- Raise lines 3 and 1 in the same cycle → irq_id = 1 first. Ack, then ERet → second request with irq_id = 3 one cycle after IDLE.
- In REQ with irq_id = 2, raise line 0 → irq_id stays 2 until ack; line 0 is granted after ERet.
- mask_wdata = 4'b1011 while REQ for source 2 with no ack → ExtIRQ drops next cycle and pending[2] stays 1. Re-enable the mask → request for 2 reappears.
- Ack and a mask write disabling sel_id in the same cycle → state SERVICE, pending bit cleared. A new edge on the same source during the ack cycle leaves pending set.
- Assert reset during SERVICE with pending = 4'b0101 → all outputs 0 next cycle. ERet or ExtIAck afterwards have no effect.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and default sizing for the interrupt sequencer slice.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } irq_state_t;

  localparam int N_SRC_DEF = 4;
  localparam int ID_W_DEF  = 2;

endpackage

// File: rtl/prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
module prio_enc #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  index
);

  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        index = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// Edge-detects interrupt lines into pending latches, arbitrates by fixed
// priority and runs the ExtIRQ/ExtIAck/ERET handshake with the core.
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             ExtIAck,
  input  logic             ERet,
  output logic             ExtIRQ,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_service,
  output logic [N_SRC-1:0] pending
);

  irq_state_t       state_q, state_d;
  logic [N_SRC-1:0] irq_prev;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] edges, eligible, clr;
  logic [ID_W-1:0]  sel_id, sel_d, enc_index;
  logic             enc_valid, grant;

  assign edges    = irq_in & ~irq_prev;
  assign eligible = pending & mask_q;
  assign mask_d   = mask_we ? mask_wdata : mask_q;

  prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req   (eligible),
    .valid (enc_valid),
    .index (enc_index)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_id;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          sel_d   = enc_index;
          state_d = REQ;
        end
      end
      REQ: begin
        // Ack takes precedence over a same-cycle mask write that would withdraw.
        if (ExtIAck) begin
          grant   = 1'b1;
          state_d = SERVICE;
        end else if (!(mask_d[sel_id] && pending[sel_id])) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (ERet) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr = '0;
    if (grant) clr[sel_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_id   <= '0;
      irq_prev <= '1;
      mask_q   <= '1;
      pending  <= '0;
    end else begin
      state_q  <= state_d;
      sel_id   <= sel_d;
      irq_prev <= irq_in;
      mask_q   <= mask_d;
      // A new edge on the granted source survives its own clear.
      pending  <= (pending & ~clr) | edges;
    end
  end

  assign ExtIRQ     = (state_q == REQ);
  assign in_service = (state_q == SERVICE);
  assign irq_id     = sel_id;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed plus randomized checks of irq_sequencer against a behavioural model.
module tb_irq_sequencer;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_in;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic         ExtIAck;
  logic         ERet;
  logic         ExtIRQ;
  logic [W-1:0] irq_id;
  logic         in_service;
  logic [N-1:0] pending;

  always #5 clk = ~clk;

  irq_sequencer #(
    .N_SRC (N),
    .ID_W  (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ExtIAck    (ExtIAck),
    .ERet       (ERet),
    .ExtIRQ     (ExtIRQ),
    .irq_id     (irq_id),
    .in_service (in_service),
    .pending    (pending)
  );

  // Reference model: requesting/servicing flags and per-line bit arrays.
  bit          m_prev [N];
  bit          m_pend [N];
  bit          m_mask [N];
  bit          m_req, m_svc;
  int          m_id;
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_step();
    bit rise [N];
    bit new_mask [N];
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_prev[i] = 1'b1; m_pend[i] = 1'b0; m_mask[i] = 1'b1;
      end
      m_req = 1'b0; m_svc = 1'b0; m_id = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      rise[i]     = irq_in[i] && !m_prev[i];
      new_mask[i] = mask_we ? mask_wdata[i] : m_mask[i];
    end
    if (!m_req && !m_svc) begin
      for (int i = N - 1; i >= 0; i--)
        if (m_pend[i] && m_mask[i]) begin m_id = i; m_req = 1'b1; end
    end else if (m_req) begin
      if (ExtIAck) begin
        m_pend[m_id] = 1'b0; m_req = 1'b0; m_svc = 1'b1;
      end else if (!new_mask[m_id] || !m_pend[m_id]) begin
        m_req = 1'b0;
      end
    end else if (ERet) begin
      m_svc = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (rise[i]) m_pend[i] = 1'b1;
      m_prev[i] = irq_in[i];
      m_mask[i] = new_mask[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("ExtIRQ",     32'(ExtIRQ),     32'(m_req));
    check("in_service", 32'(in_service), 32'(m_svc));
    check("irq_id",     32'(irq_id),     32'(m_id));
    check("pending",    32'(pending),    m_pend_vec());
  endtask

  task automatic quiet();
    mask_we = 1'b0; ExtIAck = 1'b0; ERet = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_in = 4'b0010; mask_wdata = '0; quiet();
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check("held_line_no_pend", 32'(pending), 32'h0);
    check("held_line_no_irq",  32'(ExtIRQ),  32'h0);

    // Drop and re-raise line 1: request two cycles after the rise.
    irq_in = 4'b0000; tick();
    irq_in = 4'b0010; tick();
    check("rise1_pend",  32'(pending), 32'h2);
    check("rise1_noreq", 32'(ExtIRQ),  32'h0);
    tick();
    check("rise1_req", 32'(ExtIRQ), 32'h1);
    check("rise1_id",  32'(irq_id), 32'h1);
    ExtIAck = 1'b1; tick(); quiet();
    check("ack_svc",  32'(in_service), 32'h1);
    check("ack_drop", 32'(ExtIRQ),     32'h0);
    irq_in = 4'b0000; ERet = 1'b1; tick(); quiet();

    // Lines 3 and 1 together: 1 first, then 3.
    irq_in = 4'b1010; tick(); tick();
    check("pair_first", 32'(irq_id), 32'h1);
    ExtIAck = 1'b1; tick(); quiet();
    ERet = 1'b1; tick(); quiet();
    tick();
    check("pair_second_req", 32'(ExtIRQ), 32'h1);
    check("pair_second_id",  32'(irq_id), 32'h3);
    ExtIAck = 1'b1; tick(); quiet();
    ERet = 1'b1; tick(); quiet();
    irq_in = 4'b0000; tick();

    // No re-arbitration while requesting source 2.
    irq_in = 4'b0100; tick(); tick();
    irq_in = 4'b0101; tick(); tick();
    check("frozen_id", 32'(irq_id), 32'h2);
    ExtIAck = 1'b1; tick(); quiet();
    ERet = 1'b1; tick(); quiet();
    tick();
    check("late0_id", 32'(irq_id), 32'h0);
    ExtIAck = 1'b1; tick(); quiet();
    ERet = 1'b1; tick(); quiet();

    // Mask withdraws a request without clearing pending.
    irq_in = 4'b0000; tick();
    irq_in = 4'b0100; tick(); tick();
    mask_we = 1'b1; mask_wdata = 4'b1011; tick(); quiet();
    check("masked_drop", 32'(ExtIRQ),     32'h0);
    check("masked_pend", 32'(pending[2]), 32'h1);
    tick();
    mask_we = 1'b1; mask_wdata = 4'b1111; tick(); quiet();
    tick();
    check("unmask_req", 32'(ExtIRQ), 32'h1);
    check("unmask_id",  32'(irq_id), 32'h2);

    // Ack beats a same-cycle disabling mask write.
    ExtIAck = 1'b1; mask_we = 1'b1; mask_wdata = 4'b1011; tick(); quiet();
    check("ackmask_svc",  32'(in_service), 32'h1);
    check("ackmask_pend", 32'(pending[2]), 32'h0);
    ERet = 1'b1; mask_we = 1'b1; mask_wdata = 4'b1111; tick(); quiet();

    // A fresh edge during the ack cycle keeps the bit pending.
    irq_in = 4'b0000; tick();
    irq_in = 4'b0100; tick(); tick();
    irq_in = 4'b0000; tick();
    irq_in = 4'b0100; ExtIAck = 1'b1; tick(); quiet();
    check("edge_ack_pend", 32'(pending[2]), 32'h1);
    ERet = 1'b1; tick(); quiet();
    tick();
    check("edge_ack_rereq", 32'(ExtIRQ), 32'h1);
    ExtIAck = 1'b1; tick(); quiet();
    ERet = 1'b1; tick(); quiet();

    // Reset in SERVICE with 4'b0101 pending.
    irq_in = 4'b0000; tick();
    irq_in = 4'b0010; tick(); tick();
    ExtIAck = 1'b1; tick(); quiet();
    irq_in = 4'b0111; tick();
    check("pre_reset_pend", 32'(pending), 32'h5);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_pend", 32'(pending),    32'h0);
    check("rst_svc",  32'(in_service), 32'h0);
    check("rst_irq",  32'(ExtIRQ),     32'h0);
    check("rst_id",   32'(irq_id),     32'h0);
    ERet = 1'b1; ExtIAck = 1'b1; tick(); quiet();
    check("post_rst_svc", 32'(in_service), 32'h0);
    check("post_rst_irq", 32'(ExtIRQ),     32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      irq_in     = N'($urandom);
      mask_we    = ($urandom_range(0, 7) == 0);
      mask_wdata = N'($urandom);
      ExtIAck    = ($urandom_range(0, 2) == 0);
      ERet       = ($urandom_range(0, 3) == 0);
      reset      = ($urandom_range(0, 79) == 0);
      tick();
    end
    reset = 1'b0; quiet();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
